// File: rtl/pqr5_subsystem_pkg.sv
// Shared types and helpers for the data-memory access path.
// Holds the size encoding, the per-request metadata record and the lane helpers.
package pqr5_subsystem_pkg;

  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10} mem_size_t;

  typedef struct packed {
    logic       owner;
    logic       wen;
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
    logic       err;
  } dmem_meta_t;

  function automatic logic [3:0] size_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << off;
      SZ_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Pick the addressed lane out of the raw RAM word and extend it to 32 bits.
  function automatic logic [31:0] load_fmt(input logic [31:0] raw, input logic [1:0] size,
                                           input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = raw[{off, 3'b000} +: 8];
    h = off[1] ? raw[31:16] : raw[15:0];
    case (size)
      SZ_B:    return uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_H:    return uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Requester-side bus of the data-memory access controller: two request ports
// and two response ports sharing one data/error return.
interface dmem_access_ctrl_if;
  logic [1:0]       i_req_valid;
  logic [1:0]       o_req_ready;
  logic [1:0]       i_req_wen;
  logic [1:0][1:0]  i_req_size;
  logic [1:0]       i_req_uns;
  logic [1:0][31:0] i_req_addr;
  logic [1:0][31:0] i_req_wdata;
  logic [1:0]       o_rsp_valid;
  logic [1:0]       i_rsp_ready;
  logic [31:0]      o_rsp_rdata;
  logic             o_rsp_err;

  modport master (
    output i_req_valid, i_req_wen, i_req_size, i_req_uns, i_req_addr, i_req_wdata, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport slave (
    input  i_req_valid, i_req_wen, i_req_size, i_req_uns, i_req_addr, i_req_wdata, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
endinterface

// File: rtl/dmem_rr_arb2.sv
// Two-way request arbiter; round-robin or fixed priority (port 0 first).
// The pointer moves to the non-winning port after every accepted request.
module dmem_rr_arb2 #(
  parameter bit ARB_RR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_r;

  // One-hot grant from the current requests and pointer.
  always_comb begin
    grant = 2'b00;
    if (ARB_RR) begin
      if (valid == 2'b11) begin
        grant = ptr_r ? 2'b10 : 2'b01;
      end else begin
        grant = valid;
      end
    end else begin
      if (valid[0]) begin
        grant = 2'b01;
      end else begin
        grant = valid & 2'b10;
      end
    end
  end

  // Pointer update: favour the other port after each accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= 1'b0;
    end else if (advance) begin
      ptr_r <= ~grant[1];
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Two-requester access controller for a 4-bank byte-enabled 32-bit data RAM.
// Issues one access per cycle, returns the formatted response one cycle later.
module dmem_access_ctrl
  import pqr5_subsystem_pkg::*;
#(
  parameter int  DEPTH  = 1024,
  parameter bit  ARB_RR = 1'b1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  dmem_access_ctrl_if.slave bus,
  output logic [3:0]        o_ram_en,
  output logic              o_ram_wen,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [31:0]       o_ram_wdata,
  input  logic [31:0]       i_ram_rdata
);

  logic [1:0]  grant_s;
  logic        win_s;
  logic        can_accept_s;
  logic        accept_s;
  logic        rsp_taken_s;
  logic [1:0]  req_size_s;
  logic [31:0] req_addr_s;
  logic [31:0] req_wdata_s;
  logic        req_err_s;
  logic [31:0] fmt_s;
  logic        pend_r;
  logic        hold_valid_r;
  logic [31:0] hold_data_r;
  dmem_meta_t  meta_r;

  dmem_rr_arb2 #(.ARB_RR(ARB_RR)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (bus.i_req_valid),
    .advance (accept_s),
    .grant   (grant_s)
  );

  // Winner selection, error classification and accept handshake.
  always_comb begin
    win_s        = grant_s[1];
    req_size_s   = bus.i_req_size[win_s];
    req_addr_s   = bus.i_req_addr[win_s];
    req_wdata_s  = bus.i_req_wdata[win_s];
    rsp_taken_s  = pend_r && bus.i_rsp_ready[meta_r.owner];
    can_accept_s = !pend_r || rsp_taken_s;
    case (req_size_s)
      SZ_B:    req_err_s = 1'b0;
      SZ_H:    req_err_s = req_addr_s[0];
      SZ_W:    req_err_s = (req_addr_s[1:0] != 2'b00);
      default: req_err_s = 1'b1;
    endcase
    // Anything beyond the RAM's word range is rejected as well.
    if (|req_addr_s[31:ADDR_W+2]) begin
      req_err_s = 1'b1;
    end else begin
      req_err_s = req_err_s;
    end
    if (rst) begin
      bus.o_req_ready = 2'b00;
    end else begin
      bus.o_req_ready = grant_s & {2{can_accept_s}};
    end
    accept_s = |(bus.i_req_valid & bus.o_req_ready);
  end

  // RAM issue in the accept cycle; erroneous requests are acked but never touch the RAM.
  always_comb begin
    o_ram_addr = req_addr_s[ADDR_W+1:2];
    case (req_size_s)
      SZ_B:    o_ram_wdata = {4{req_wdata_s[7:0]}};
      SZ_H:    o_ram_wdata = {2{req_wdata_s[15:0]}};
      default: o_ram_wdata = req_wdata_s;
    endcase
    if (accept_s && !req_err_s) begin
      o_ram_en = size_en(req_size_s, req_addr_s[1:0]);
    end else begin
      o_ram_en = 4'b0000;
    end
    if (accept_s) begin
      o_ram_wen = bus.i_req_wen[win_s];
    end else begin
      o_ram_wen = 1'b0;
    end
  end

  // Response outputs: fresh RAM data on the first cycle, the hold register afterwards.
  always_comb begin
    if (meta_r.wen || meta_r.err) begin
      fmt_s = 32'd0;
    end else begin
      fmt_s = load_fmt(i_ram_rdata, meta_r.size, meta_r.off, meta_r.uns);
    end
    if (pend_r) begin
      bus.o_rsp_valid = meta_r.owner ? 2'b10 : 2'b01;
      bus.o_rsp_rdata = hold_valid_r ? hold_data_r : fmt_s;
      bus.o_rsp_err   = meta_r.err;
    end else begin
      bus.o_rsp_valid = 2'b00;
      bus.o_rsp_rdata = 32'd0;
      bus.o_rsp_err   = 1'b0;
    end
  end

  // Pending response, its metadata and the back-pressure hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r       <= 1'b0;
      meta_r       <= '0;
      hold_valid_r <= 1'b0;
      hold_data_r  <= 32'd0;
    end else if (accept_s) begin
      pend_r       <= 1'b1;
      meta_r       <= '{owner: win_s, wen: bus.i_req_wen[win_s], size: req_size_s,
                        uns: bus.i_req_uns[win_s], off: req_addr_s[1:0], err: req_err_s};
      hold_valid_r <= 1'b0;
    end else if (rsp_taken_s) begin
      pend_r       <= 1'b0;
      hold_valid_r <= 1'b0;
    end else if (pend_r && !hold_valid_r) begin
      hold_valid_r <= 1'b1;
      hold_data_r  <= fmt_s;
    end else begin
      hold_valid_r <= hold_valid_r;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios followed by
// random single accesses, all checked against a byte-array memory model.
module tb_dmem_access_ctrl;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic env_clr = 1'b1;
  always #5 clk = ~clk;

  dmem_access_ctrl_if bus ();
  dmem_access_ctrl_if bus2 ();

  logic [3:0]  ram_en, ram2_en;
  logic        ram_wen, ram2_wen;
  logic [9:0]  ram_addr, ram2_addr;
  logic [31:0] ram_wdata, ram2_wdata, ram_rdata;

  dmem_access_ctrl #(.DEPTH(DEPTH), .ARB_RR(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .o_ram_en(ram_en), .o_ram_wen(ram_wen),
    .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
  );

  dmem_access_ctrl #(.DEPTH(DEPTH), .ARB_RR(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .bus(bus2), .o_ram_en(ram2_en), .o_ram_wen(ram2_wen),
    .o_ram_addr(ram2_addr), .o_ram_wdata(ram2_wdata), .i_ram_rdata(32'd0)
  );

  // Synchronous RAM: unwritten words read as a fixed pattern; data is only valid after a read.
  logic [31:0]   env_mem [DEPTH];
  logic [1023:0] env_wr;

  function automatic logic [31:0] pat(input int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'h0F1E2D3C;
  endfunction

  function automatic logic [31:0] env_word(input logic [9:0] a);
    return env_wr[a] ? env_mem[a] : pat(int'(a));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] en);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (en[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (env_clr) begin
      env_wr <= '0;
    end else if (ram_wen && ram_en != 4'b0000) begin
      env_mem[ram_addr] <= merge(env_word(ram_addr), ram_wdata, ram_en);
      env_wr[ram_addr]  <= 1'b1;
    end
    if (ram_en != 4'b0000 && !ram_wen) ram_rdata <= env_word(ram_addr);
    else ram_rdata <= $urandom;
  end

  // Reference model: byte-addressed memory and access rules.
  logic [7:0] model_mem [4*DEPTH];
  int  checks = 0;
  int  errors = 0;
  bit  exp_ptr = 1'b0;

  function automatic int nbytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic bit m_err(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'b11) || (addr % nbytes(size) != 0) || (addr >= 32'(4 * DEPTH));
  endfunction

  function automatic logic [3:0] m_en(input logic [1:0] size, input logic [31:0] addr);
    int m;
    if (m_err(size, addr)) return 4'b0000;
    m = ((1 << nbytes(size)) - 1) << (addr % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] d);
    if (nbytes(size) == 1) return 32'(d[7:0]) * 32'h01010101;
    if (nbytes(size) == 2) return 32'(d[15:0]) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input bit uns, input logic [31:0] addr);
    longint v;
    int n;
    n = nbytes(size);
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(model_mem[addr + i]) << (8 * i);
    if (!uns && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One access on port p with an immediately ready response.
  task automatic do_op(input int p, input bit wen, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] d);
    bit e;
    logic [31:0] exp_rd;
    e = m_err(size, addr);
    exp_rd = (wen || e) ? 32'd0 : m_load(size, uns, addr);
    @(negedge clk);
    bus.i_req_valid    = 2'b00;
    bus.i_req_valid[p] = 1'b1;
    bus.i_req_wen[p]   = wen;
    bus.i_req_size[p]  = size;
    bus.i_req_uns[p]   = uns;
    bus.i_req_addr[p]  = addr;
    bus.i_req_wdata[p] = d;
    bus.i_rsp_ready    = 2'b11;
    #1;
    chk("req_ready", 32'(bus.o_req_ready), (p == 0) ? 32'd1 : 32'd2);
    chk("ram_en", 32'(ram_en), 32'(m_en(size, addr)));
    chk("ram_wen", 32'(ram_wen), 32'(wen));
    if (!e) begin
      chk("ram_addr", 32'(ram_addr), 32'(addr[11:2]));
      if (wen) chk("ram_wdata", ram_wdata, m_wdata(size, d));
    end
    @(posedge clk);
    if (wen && !e) for (int i = 0; i < nbytes(size); i++) model_mem[addr + i] = d[8*i +: 8];
    exp_ptr = (p == 0);
    @(negedge clk);
    bus.i_req_valid = 2'b00;
    #1;
    chk("rsp_valid", 32'(bus.o_rsp_valid), (p == 0) ? 32'd1 : 32'd2);
    chk("rsp_err", 32'(bus.o_rsp_err), 32'(e));
    chk("rsp_rdata", bus.o_rsp_rdata, exp_rd);
  endtask

  initial begin
    logic [31:0] v, exp0, held;
    logic [1:0]  g, prevg, sz;
    logic [31:0] a;

    for (int w = 0; w < DEPTH; w++) begin
      v = pat(w);
      for (int b = 0; b < 4; b++) model_mem[4*w + b] = v[8*b +: 8];
    end
    bus.i_req_valid = 2'b01; bus.i_req_wen = 2'b00; bus.i_req_uns = 2'b00;
    bus.i_req_size = '{2'b10, 2'b10}; bus.i_req_addr = '{32'h24, 32'h10};
    bus.i_req_wdata = '{32'd0, 32'd0}; bus.i_rsp_ready = 2'b11;
    bus2.i_req_valid = 2'b11; bus2.i_req_wen = 2'b00; bus2.i_req_uns = 2'b00;
    bus2.i_req_size = '{2'b10, 2'b10}; bus2.i_req_addr = '{32'h4, 32'h0};
    bus2.i_req_wdata = '{32'd0, 32'd0}; bus2.i_rsp_ready = 2'b11;

    // Reset state, with a request held valid to show nothing leaks to the RAM.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(bus.o_rsp_err), 32'd0);
    chk("rst_rsp_rdata", bus.o_rsp_rdata, 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_req_ready", 32'(bus.o_req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0; env_clr = 1'b0; bus.i_req_valid = 2'b00;

    // Directed word, byte, error and boundary accesses.
    do_op(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    do_op(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    chk("lw_deadbeef_model", m_load(2'b10, 1'b0, 32'h10), 32'hDEADBEEF);
    do_op(1, 1'b1, 2'b00, 1'b0, 32'h13, 32'h80);
    do_op(1, 1'b0, 2'b00, 1'b0, 32'h13, 32'd0);
    do_op(1, 1'b0, 2'b00, 1'b1, 32'h13, 32'd0);
    do_op(0, 1'b0, 2'b01, 1'b0, 32'h11, 32'd0);
    do_op(0, 1'b0, 2'b10, 1'b0, 32'h12, 32'd0);
    do_op(0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h11111111);
    do_op(1, 1'b1, 2'b11, 1'b0, 32'h10, 32'h22222222);
    do_op(0, 1'b1, 2'b10, 1'b0, 32'h1000, 32'h33333333);
    do_op(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    do_op(1, 1'b1, 2'b01, 1'b0, 32'hFFE, 32'h0000C0DE);
    do_op(1, 1'b0, 2'b10, 1'b0, 32'hFFC, 32'd0);

    // Both ports streaming loads: alternating grants at one per cycle.
    @(negedge clk);
    bus.i_req_valid = 2'b11; bus.i_req_wen = 2'b00; bus.i_req_uns = 2'b00;
    bus.i_req_size = '{2'b10, 2'b10}; bus.i_req_addr = '{32'h24, 32'h20};
    prevg = 2'b00;
    for (int k = 0; k < 6; k++) begin
      #1;
      g = exp_ptr ? 2'b10 : 2'b01;
      chk("rr_grant", 32'(bus.o_req_ready), 32'(g));
      chk("rr_ram_en", 32'(ram_en), 32'hF);
      chk("fp_grant", 32'(bus2.o_req_ready), 32'd1);
      if (k > 0) begin
        chk("rr_rsp_valid", 32'(bus.o_rsp_valid), 32'(prevg));
        chk("rr_rsp_rdata", bus.o_rsp_rdata, m_load(2'b10, 1'b0, prevg[1] ? 32'h24 : 32'h20));
        chk("fp_rsp_valid", 32'(bus2.o_rsp_valid), 32'd1);
      end
      prevg = g;
      exp_ptr = ~g[1];
      @(negedge clk);
    end
    bus.i_req_valid = 2'b00;
    #1;
    chk("rr_last_rsp", 32'(bus.o_rsp_valid), 32'(prevg));

    // Back-pressure on port 0 for three cycles.
    @(negedge clk);
    bus.i_req_valid = 2'b01; bus.i_req_addr[0] = 32'h10; bus.i_rsp_ready = 2'b00;
    exp0 = m_load(2'b10, 1'b0, 32'h10);
    #1;
    chk("bp_accept", 32'(bus.o_req_ready), 32'd1);
    @(negedge clk);
    bus.i_req_valid = 2'b10;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("bp_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
      chk("bp_rdata", bus.o_rsp_rdata, exp0);
      chk("bp_req_ready", 32'(bus.o_req_ready), 32'd0);
      chk("bp_ram_en", 32'(ram_en), 32'd0);
      @(negedge clk);
    end
    bus.i_rsp_ready = 2'b01;
    #1;
    held = bus.o_rsp_rdata;
    chk("bp_release_rdata", held, exp0);
    chk("bp_release_ready", 32'(bus.o_req_ready), 32'd2);
    chk("bp_release_en", 32'(ram_en), 32'hF);
    @(negedge clk);
    bus.i_req_valid = 2'b00; bus.i_rsp_ready = 2'b11;
    #1;
    chk("bp_next_valid", 32'(bus.o_rsp_valid), 32'd2);
    chk("bp_next_rdata", bus.o_rsp_rdata, m_load(2'b10, 1'b0, 32'h24));
    exp_ptr = 1'b0;

    // Reset while a load response is pending.
    @(negedge clk);
    bus.i_req_valid = 2'b01; bus.i_rsp_ready = 2'b00;
    #1;
    chk("mid_accept", 32'(bus.o_req_ready), 32'd1);
    @(negedge clk);
    bus.i_req_valid = 2'b11; rst = 1'b1;
    #1;
    chk("mid_pending", 32'(bus.o_rsp_valid), 32'd1);
    chk("mid_rst_ram_en", 32'(ram_en), 32'd0);
    @(negedge clk);
    rst = 1'b0; bus.i_rsp_ready = 2'b11;
    #1;
    chk("mid_no_rsp", 32'(bus.o_rsp_valid), 32'd0);
    chk("mid_ptr_reset", 32'(bus.o_req_ready), 32'd1);
    @(negedge clk);
    bus.i_req_valid = 2'b00;
    #1;
    chk("mid_new_rsp", 32'(bus.o_rsp_valid), 32'd1);
    chk("mid_new_rdata", bus.o_rsp_rdata, m_load(2'b10, 1'b0, 32'h10));
    exp_ptr = 1'b1;

    // Random single accesses.
    for (int r = 0; r < 60; r++) begin
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 9) == 0) ? 32'h1000 + $urandom_range(0, 255) : 32'($urandom_range(0, 255));
      do_op(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
